// File: rtl/debounce_array_if.sv
// Pin-side and conditioned-output bundle for debounce_array.
// The slave modport is the conditioner; the master modport is its user.
interface debounce_array_if #(
    parameter int unsigned N_CH = 16
);
    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] long_pulse;
    logic [N_CH-1:0] long_level;
    logic            any_rise;

    modport master (
        output raw_in,
        input  level, rise, fall, long_pulse, long_level, any_rise
    );

    modport slave (
        input  raw_in,
        output level, rise, fall, long_pulse, long_level, any_rise
    );
endinterface

// File: rtl/debounce_array.sv
// Multi-channel input conditioner: per-channel 2-flop sync, debounce and
// long-press detection, with registered edge and long-press pulses.
module debounce_array #(
    parameter int unsigned     N_CH       = 16,
    parameter int unsigned     STABLE_CNT = 100000,
    parameter int unsigned     LONG_CNT   = 200000000,
    parameter int unsigned     CNT_W      = 32,
    parameter logic [N_CH-1:0] INV_MASK   = '0
) (
    input logic             clk,
    input logic             rst,
    debounce_array_if.slave bus
);
    localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CNT - 1);
    localparam bit               LONG_EN   = (LONG_CNT != 0);
    localparam logic [CNT_W-1:0] LONG_TC   = LONG_EN ? CNT_W'(LONG_CNT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [N_CH-1:0]  r_s1;
    logic [N_CH-1:0]  r_s2;
    logic [N_CH-1:0]  r_level;
    logic [N_CH-1:0]  r_rise;
    logic [N_CH-1:0]  r_fall;
    logic [N_CH-1:0]  r_long_pulse;
    logic [N_CH-1:0]  r_long_level;
    logic             r_any_rise;
    logic [CNT_W-1:0] r_dcnt [N_CH];
    logic [CNT_W-1:0] r_lcnt [N_CH];

    logic [N_CH-1:0]  w_x;
    logic [N_CH-1:0]  w_accept;
    logic [N_CH-1:0]  w_level_d;

    always_comb begin
        w_x      = bus.raw_in ^ INV_MASK;
        w_accept = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            w_accept[i] = (r_s2[i] != r_level[i]) && (r_dcnt[i] == STABLE_TC);
        end
        w_level_d = r_level ^ w_accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1         <= '0;
            r_s2         <= '0;
            r_level      <= '0;
            r_rise       <= '0;
            r_fall       <= '0;
            r_long_pulse <= '0;
            r_long_level <= '0;
            r_any_rise   <= 1'b0;
            for (int i = 0; i < int'(N_CH); i++) begin
                r_dcnt[i] <= '0;
                r_lcnt[i] <= '0;
            end
        end else begin
            r_s1       <= w_x;
            r_s2       <= r_s1;
            r_level    <= w_level_d;
            r_rise     <= w_accept & r_s2;
            r_fall     <= w_accept & ~r_s2;
            r_any_rise <= |(w_accept & r_s2);
            for (int i = 0; i < int'(N_CH); i++) begin
                if ((r_s2[i] == r_level[i]) || w_accept[i]) begin
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + CNT_ONE;
                end
                // Gating on the next level lets a fall pre-empt a coincident long-press.
                if (!LONG_EN || !(r_level[i] && w_level_d[i])) begin
                    r_lcnt[i]       <= '0;
                    r_long_level[i] <= 1'b0;
                    r_long_pulse[i] <= 1'b0;
                end else if (r_lcnt[i] != LONG_TC) begin
                    r_lcnt[i]       <= r_lcnt[i] + CNT_ONE;
                    r_long_pulse[i] <= 1'b0;
                end else begin
                    r_long_pulse[i] <= !r_long_level[i];
                    r_long_level[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.level      = r_level;
    assign bus.rise       = r_rise;
    assign bus.fall       = r_fall;
    assign bus.long_pulse = r_long_pulse;
    assign bus.long_level = r_long_level;
    assign bus.any_rise   = r_any_rise;
endmodule

// File: tb/tb_debounce_array.sv
// Randomised and directed bench for debounce_array, checked every cycle
// against a window-based reference model of the debounce/long-press rules.
module tb_debounce_array;
    localparam int unsigned N_CH   = 4;
    localparam int unsigned STABLE = 8;
    localparam int unsigned LONG   = 32;
    localparam int unsigned CNT_W  = 32;
    localparam logic [3:0]  INV    = 4'b1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    debounce_array_if #(.N_CH(N_CH)) bus ();

    debounce_array #(
        .N_CH      (N_CH),
        .STABLE_CNT(STABLE),
        .LONG_CNT  (LONG),
        .CNT_W     (CNT_W),
        .INV_MASK  (INV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: sync delay line, last STABLE synced samples,
    // and the number of edges the level has been continuously high.
    logic [3:0]        m_s1, m_s2, m_level, m_rise, m_fall, m_lp, m_ll;
    logic [STABLE-1:0] m_hist [N_CH];
    int                m_fill [N_CH];
    int                m_age  [N_CH];
    int                rem    [N_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0;
        m_rise = '0; m_fall = '0; m_lp = '0; m_ll = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            m_hist[c] = '0;
            m_fill[c] = 0;
            m_age[c]  = 0;
        end
    endtask

    task automatic model_edge();
        logic [3:0] x;
        logic       acc, nl;
        x      = bus.raw_in ^ INV;
        m_rise = '0;
        m_fall = '0;
        m_lp   = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            m_hist[c] = {m_hist[c][STABLE-2:0], m_s2[c]};
            if (m_fill[c] < int'(STABLE)) m_fill[c]++;
            // Accept only when every one of the last STABLE samples disagreed with level.
            acc = (m_fill[c] == int'(STABLE)) && (m_hist[c] == {STABLE{~m_level[c]}});
            if (acc) m_fill[c] = 0;
            nl        = m_level[c] ^ acc;
            m_rise[c] = acc && nl;
            m_fall[c] = acc && !nl;
            if (nl && m_level[c]) m_age[c]++;
            else m_age[c] = 0;
            m_lp[c]    = nl && m_level[c] && (m_age[c] == int'(LONG));
            m_ll[c]    = nl && (m_age[c] >= int'(LONG));
            m_level[c] = nl;
        end
        m_s2 = m_s1;
        m_s1 = x;
    endtask

    task automatic compare_all();
        check("level",      32'(bus.level),      32'(m_level));
        check("rise",       32'(bus.rise),       32'(m_rise));
        check("fall",       32'(bus.fall),       32'(m_fall));
        check("long_pulse", 32'(bus.long_pulse), 32'(m_lp));
        check("long_level", 32'(bus.long_level), 32'(m_ll));
        check("any_rise",   32'(bus.any_rise),   32'(|m_rise));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Asserted off the clock edge; outputs must clear without waiting for one.
    task automatic do_reset(input int hold);
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_async_level", 32'(bus.level), 32'h0);
        check("rst_async_any",   32'({bus.rise, bus.fall, bus.long_pulse, bus.long_level,
                                      bus.any_rise}), 32'h0);
        run(hold);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        bus.raw_in = 4'b1000;
        run(3);
        rst = 1'b0;

        // Idle with every conditioned input at 0.
        run(100);
        check("idle_level", 32'(bus.level), 32'h0);

        // Single clean rise on channel 0.
        bus.raw_in[0] = 1'b1;
        run(20);
        check("ch0_level", 32'(bus.level[0]), 32'h1);

        // Bounce on channel 1, then a clean hold.
        bus.raw_in[1] = 1'b1; run(5);
        bus.raw_in[1] = 1'b0; run(2);
        bus.raw_in[1] = 1'b1; run(7);
        bus.raw_in[1] = 1'b0; run(12);
        check("ch1_bounce", 32'(bus.level[1]), 32'h0);
        bus.raw_in[1] = 1'b1; run(12);
        bus.raw_in[1] = 1'b0; run(12);

        // Long press on channel 2, then release.
        bus.raw_in[2] = 1'b1; run(55);
        check("ch2_long_level", 32'(bus.long_level[2]), 32'h1);
        bus.raw_in[2] = 1'b0; run(15);
        check("ch2_released", 32'(bus.long_level[2]), 32'h0);

        // Inverted channel 3: raw low means active.
        bus.raw_in[3] = 1'b0; run(15);
        check("ch3_inverted", 32'(bus.level[3]), 32'h1);
        bus.raw_in[3] = 1'b1; run(15);

        // Reset mid-long-press on ch2 and mid-debounce on ch0.
        bus.raw_in[2] = 1'b1; run(25);
        bus.raw_in[0] = 1'b0; run(7);
        do_reset(3);
        run(60);

        // Random toggling: short bursts (bounces) mixed with long holds.
        for (int c = 0; c < int'(N_CH); c++) rem[c] = $urandom_range(1, 20);
        for (int cyc = 0; cyc < 2400; cyc++) begin
            for (int c = 0; c < int'(N_CH); c++) begin
                if (rem[c] == 0) begin
                    bus.raw_in[c] = ~bus.raw_in[c];
                    rem[c] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 7)
                                                         : $urandom_range(9, 60);
                end else begin
                    rem[c]--;
                end
            end
            if (cyc == 800 || cyc == 1600) do_reset($urandom_range(1, 4));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
